// File: rtl/compare_in_loader.sv
// Serial receiver for the riscv_top compare_in bus: synchronizes a cs_n-framed MSB-first word
// and commits it only on a well-formed frame. Optional parity bit: define COMPARE_LOADER_PARITY_EN.
module compare_in_loader #(
  parameter int DATA_W      = 24,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ser_clk_in,
  input  logic              ser_data_in,
  input  logic              ser_cs_n_in,
  output logic [2:0]        io_oeb,
  output logic [DATA_W-1:0] compare_out,
  output logic              compare_valid,
  output logic              frame_err,
  output logic              busy
);

`ifdef COMPARE_LOADER_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 1;
`else
  localparam int FRAME_BITS = DATA_W;
`endif
  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, ABORT} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync, r_cs_sync;
  logic                  r_clk_d, r_cs_d;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [TMO_W-1:0]      r_tmo;
  logic [DATA_W-1:0]     r_compare_out;
  logic                  r_compare_valid, r_frame_err;

  logic w_clk_s, w_data_s, w_cs_s;
  logic w_sclk_rise, w_cs_fall, w_cs_rise;
  logic w_start, w_shift_en, w_tmo_tick, w_parity_ok;
  logic [DATA_W-1:0] w_word;

  // cs_n idles high, so its synchronizer resets to 1 to avoid a false frame start
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_clk_sync  <= '0;
      r_data_sync <= '0;
      r_cs_sync   <= '1;
      r_clk_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ser_clk_in};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ser_data_in};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], ser_cs_n_in};
      r_clk_d     <= w_clk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s    = r_data_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_clk_s & ~r_clk_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;

`ifdef COMPARE_LOADER_PARITY_EN
  assign w_parity_ok = ~^r_shift;
  assign w_word      = r_shift[FRAME_BITS-1:1];
`else
  assign w_parity_ok = 1'b1;
  assign w_word      = r_shift;
`endif

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // cs_rise takes priority over a coincident serial-clock edge
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_shift_en   = 1'b0;
    w_tmo_tick   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_next = SHIFT;
          w_start      = 1'b1;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          if ((r_bit_cnt == CNT_W'(FRAME_BITS)) && w_parity_ok) w_state_next = COMMIT;
          else                                                   w_state_next = ABORT;
        end else if (w_sclk_rise) begin
          w_shift_en = 1'b1;
        end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
          w_state_next = ABORT;
        end else begin
          w_tmo_tick = 1'b1;
        end
      end
      COMMIT:  w_state_next = IDLE;
      ABORT:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shift         <= '0;
      r_bit_cnt       <= '0;
      r_tmo           <= '0;
      r_compare_out   <= '0;
      r_compare_valid <= 1'b0;
      r_frame_err     <= 1'b0;
    end else begin
      if (w_start) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
        r_tmo     <= '0;
      end else if (w_shift_en) begin
        r_shift <= {r_shift[FRAME_BITS-2:0], w_data_s};
        if (r_bit_cnt != CNT_W'(FRAME_BITS + 1)) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        r_tmo <= '0;
      end else if (w_tmo_tick) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
      r_compare_valid <= (r_state == COMMIT);
      r_frame_err     <= (r_state == ABORT);
      if (r_state == COMMIT) r_compare_out <= w_word;
    end
  end

  assign io_oeb        = 3'b111;
  assign compare_out   = r_compare_out;
  assign compare_valid = r_compare_valid;
  assign frame_err     = r_frame_err;
  assign busy          = (r_state == SHIFT);

endmodule

// File: tb/tb_compare_in_loader.sv
// Bench for compare_in_loader: table of frames plus hand-written timeout, reset and parity cases,
// with a queue of expected commit/error events checked whenever the DUT pulses.
module tb_compare_in_loader;

`ifdef COMPARE_LOADER_PARITY_EN
  localparam int FB = 25;
`else
  localparam int FB = 24;
`endif
  localparam int TMO = 1023;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, sdata, cs_n;
  logic [2:0]  io_oeb;
  logic [23:0] compare_out;
  logic        compare_valid, frame_err, busy;

  compare_in_loader #(.DATA_W(24), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(rst_n), .ser_clk_in(sclk), .ser_data_in(sdata), .ser_cs_n_in(cs_n),
    .io_oeb(io_oeb), .compare_out(compare_out), .compare_valid(compare_valid),
    .frame_err(frame_err), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [23:0] word;
  } exp_t;

  typedef struct {
    logic [31:0] bits;
    int          n;
    bit          ok;
    logic [23:0] word;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        tbl[6];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          evt_cyc = 0;
  int          rise_cyc = 0;
  logic [23:0] model = 24'h0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (compare_valid || frame_err)) begin
      evt_cyc = cyc;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: valid=%b err=%b out=%h", compare_valid, frame_err, compare_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("event at cycle %0d: valid=%b err=%b out=%h", cyc, compare_valid, frame_err, compare_out);
        chk("event_kind", {30'b0, compare_valid, frame_err}, e.is_err ? 32'd1 : 32'd2);
        chk("event_word", {8'b0, compare_out}, {8'b0, e.word});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] frm(input logic [23:0] w);
`ifdef COMPARE_LOADER_PARITY_EN
    return {7'b0, w, ^w};
`else
    return {8'b0, w};
`endif
  endfunction

  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdata = bits[i];
      sclk  = 1'b0;
      tick(4);
      sclk  = 1'b1;
      tick(4);
    end
    sclk = 1'b0;
    tick(4);
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n);
    cs_n = 1'b0;
    tick(4);
    shift_bits(bits, n);
    cs_n = 1'b1;
    rise_cyc = cyc;
  endtask

  task automatic expect_evt(input bit is_err, input logic [23:0] w);
    exp_t e;
    e.is_err = is_err;
    e.word   = w;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d expected events never arrived within %0d cycles", name, sb_q.size(), budget);
      sb_q.delete();
    end
    tick(6);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{frm(24'hA5C30F),                FB,     1'b1, 24'hA5C30F};
    tbl[1] = '{frm(24'h123456),                FB,     1'b1, 24'h123456};
    tbl[2] = '{frm(24'h654321) >> 1,           FB - 1, 1'b0, 24'h0};
    tbl[3] = '{(frm(24'hABCDEF) << 1) | 32'h1, FB + 1, 1'b0, 24'h0};
    tbl[4] = '{frm(24'h000000),                FB,     1'b1, 24'h000000};
    tbl[5] = '{frm(24'h5A5A5A),                FB,     1'b1, 24'h5A5A5A};

    rst_n = 1'b0; sclk = 1'b0; sdata = 1'b0; cs_n = 1'b1;
    tick(1);
    chk("oeb_in_reset", {29'b0, io_oeb}, 32'h7);
    tick(3);
    rst_n = 1'b1;
    tick(10);
    chk("reset_out",   {8'b0, compare_out}, 32'h0);
    chk("reset_valid", {31'b0, compare_valid}, 32'h0);
    chk("reset_err",   {31'b0, frame_err}, 32'h0);
    chk("reset_busy",  {31'b0, busy}, 32'h0);
    chk("reset_oeb",   {29'b0, io_oeb}, 32'h7);

    for (int v = 0; v < 6; v++) begin
      if (tbl[v].ok) begin
        model = tbl[v].word;
        expect_evt(1'b0, model);
      end else begin
        expect_evt(1'b1, model);
      end
      $display("vector %0d: bits=%h n=%0d ok=%0b", v, tbl[v].bits, tbl[v].n, tbl[v].ok);
      send_frame(tbl[v].bits, tbl[v].n);
      wait_drain("vec_event", 40);
      if (tbl[v].ok) chk("commit_latency", 32'(evt_cyc - rise_cyc), 32'd4);
      chk("vec_busy_after", {31'b0, busy}, 32'h0);
      chk("vec_out_after", {8'b0, compare_out}, {8'b0, model});
    end

    // Serial clock stops mid-frame: only the timeout can end it
    expect_evt(1'b1, model);
    cs_n = 1'b0;
    tick(4);
    shift_bits(32'h15, 5);
    tick(500);
    chk("timeout_busy_mid", {31'b0, busy}, 32'h1);
    chk("timeout_no_early", sb_q.size(), 32'd1);
    wait_drain("timeout_err", TMO + 50);
    chk("timeout_busy_drop", {31'b0, busy}, 32'h0);
    cs_n = 1'b1;
    tick(6);
    model = 24'h000001;
    expect_evt(1'b0, model);
    send_frame(frm(24'h000001), FB);
    wait_drain("after_timeout_commit", 40);

    // Reset after 12 bits: word discarded, no error pulse
    cs_n = 1'b0;
    tick(4);
    shift_bits(frm(24'hC0FFEE) >> (FB - 12), 12);
    rst_n = 1'b0;
    cs_n  = 1'b1;
    tick(5);
    chk("midreset_oeb", {29'b0, io_oeb}, 32'h7);
    rst_n = 1'b1;
    tick(3);
    model = 24'h0;
    chk("midreset_out",  {8'b0, compare_out}, 32'h0);
    chk("midreset_busy", {31'b0, busy}, 32'h0);
    tick(6);
    model = 24'hFFFFFF;
    expect_evt(1'b0, model);
    send_frame(frm(24'hFFFFFF), FB);
    wait_drain("after_reset_commit", 40);
    chk("final_ffffff", {8'b0, compare_out}, 32'h00FFFFFF);

`ifdef COMPARE_LOADER_PARITY_EN
    model = 24'h000003;
    expect_evt(1'b0, model);
    send_frame({7'b0, 24'h000003, 1'b0}, 25);
    wait_drain("parity_good", 40);
    expect_evt(1'b1, model);
    send_frame({7'b0, 24'h000003, 1'b1}, 25);
    wait_drain("parity_bad", 40);
    chk("parity_bad_hold", {8'b0, compare_out}, 32'h3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/compare_in_loader.md
# compare_in_loader

Serial input receiver that feeds the 24-bit `compare_in` bus of `riscv_top`. It is the inbound counterpart of the LED output path: three `io_in` pins carry a chip-select-framed, MSB-first serial word from off-chip. The block synchronizes the pins, shifts the word in, and commits it atomically to `compare_out` only when the frame is well-formed. It sits in `user_project_wrapper` between `io_in[17:15]` and `riscv_top.compare_in`.

## Interface
Parameters:
- `DATA_W`, 24, width of the committed compare word.
- `SYNC_STAGES`, 2, flip-flop stages in each pin synchronizer (minimum 2).
- `TIMEOUT`, 1023, `clk` cycles without a serial-clock rising edge inside a frame before the frame aborts.

Ports:
- `clk` input 1: system clock, driven from `wb_clk_i`.
- `reset` input 1: reset, synchronous, active-low.
- `ser_clk_in` input 1: serial clock pin (`io_in[15]`).
- `ser_data_in` input 1: serial data pin (`io_in[16]`).
- `ser_cs_n_in` input 1: frame select pin, active-low (`io_in[17]`).
- `io_oeb` output 3: output-enable-bar for pins 17:15; constant `3'b111`, all inputs.
- `compare_out` output DATA_W: last committed word; drives `compare_in`.
- `compare_valid` output 1: one-cycle pulse when `compare_out` updates.
- `frame_err` output 1: one-cycle pulse when a frame is discarded.
- `busy` output 1: high while the FSM is in SHIFT.

## Operation
- Each pin passes through a `SYNC_STAGES` synchronizer, then one edge-detect register.
- Edge detection uses the synchronized signals only: `sclk_rise`, `cs_fall`, `cs_rise`.
- FSM states: IDLE, SHIFT, COMMIT, ABORT.
- IDLE:
  - On `cs_fall`, go to SHIFT.
  - On entry to SHIFT, clear the bit counter, the shift register and the timeout counter.
- SHIFT:
  - Each `sclk_rise` shifts the synchronized data in at the LSB, so the first bit received ends up as the MSB.
  - Each `sclk_rise` increments the bit counter, which saturates at FRAME_BITS+1.
  - Each `sclk_rise` reloads the timeout counter.
- Leaving SHIFT on `cs_rise`:
  - Go to COMMIT if the counter equals FRAME_BITS.
  - Otherwise go to ABORT. This covers short frames and over-long frames.
- Timeout: reaching `TIMEOUT` without an edge goes to ABORT.
- COMMIT:
  - Load `compare_out` and pulse `compare_valid` for one cycle.
  - Return to IDLE.
- ABORT:
  - Pulse `frame_err` for one cycle; `compare_out` is unchanged.
  - If the timeout caused the abort, wait in IDLE for the next `cs_fall`.
- FRAME_BITS is `DATA_W`, or `DATA_W+1` when parity is compiled in.
- Ignored pin activity:
  - `sclk_rise` while in IDLE is ignored.
  - `cs_fall` while in SHIFT is ignored.
- Simultaneous events:
  - `sclk_rise` together with `cs_rise`: `cs_rise` wins and the edge is not counted.
  - `sclk_rise` together with `cs_fall` in IDLE: the edge is not counted.
- `busy` reflects the registered FSM state.

## Timing
- Pin to detected edge: `SYNC_STAGES`+1 `clk` cycles.
- Final `cs_rise` pin edge to `compare_valid`: `SYNC_STAGES`+2 cycles. `compare_out` is valid in the same cycle as the pulse.
- Serial clock high and low phases must each be at least `SYNC_STAGES`+1 `clk` cycles. Faster toggling drops bits, which is detected as a short frame.
- Reset values:
  - `compare_out` = 0, `compare_valid` = 0, `frame_err` = 0, `busy` = 0.
  - FSM in IDLE; synchronizer stages = 1 for cs and 0 for clk/data.
- Reset mid-frame: the partial word is discarded, `compare_out` returns to 0, and no error pulse is produced.
- `io_oeb` = `3'b111` in every cycle, including during reset.

## Configuration
- Macro: `COMPARE_LOADER_PARITY_EN`.
- Defined:
  - The frame carries `DATA_W`+1 bits; the final bit is an even-parity bit over the data bits.
  - A parity mismatch on an otherwise correct-length frame goes to ABORT.
  - The parity bit is never stored.
- Undefined:
  - The frame is exactly `DATA_W` bits with no parity logic.
  - A `DATA_W`+1-bit frame is an over-length error.

## Test plan
- Reset, then idle pins -> `compare_out`=0, no pulses, `io_oeb`=3'b111, `busy`=0.
- Frame 24'hA5C30F, clock period 8 `clk` -> `compare_out`=24'hA5C30F and one `compare_valid` pulse, 4 cycles after the `cs_n` rise.
- 23-bit frame after a good 24'h123456 -> one `frame_err` pulse; `compare_out` stays 24'h123456.
- `cs_n` low, 5 bits, then serial clock stops -> `frame_err` after `TIMEOUT` cycles, `busy` drops; a following good 24'h000001 frame commits.
- Reset asserted after 12 bits -> `compare_out`=0, IDLE; the next full frame 24'hFFFFFF commits.
- With `COMPARE_LOADER_PARITY_EN`:
  - 24'h000003 with parity bit 0 -> commits.
  - Same word with parity bit 1 -> `frame_err`, no commit.
